prompt_screen_ctrl: RTL

//  Sequences the "PRESS ANY KEY" glyph bitmap on the start screen of the entertainment system.

---
 rtl/prompt_screen_ctrl_if.sv | 29 ++
 rtl/prompt_screen_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/prompt_screen_ctrl_if.sv
// Pixel, frame and key bus between the VGA timing / keyboard side and the prompt
// screen controller, including the glyph bitmap lookup path.
`timescale 1ns/1ps
interface prompt_screen_ctrl_if;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        pix_valid;
   logic        frame_start;
   logic        key_valid;
   logic        game_over;
   logic        letter_pix;
   logic [7:0]  letter_x;
   logic [7:0]  letter_y;
   logic [15:0] pix_data;
   logic        pix_data_valid;
   logic        in_box;
   logic        prompt_active;
   logic        game_start;

   modport master (
      output pix_x, pix_y, pix_valid, frame_start, key_valid, game_over, letter_pix,
      input  letter_x, letter_y, pix_data, pix_data_valid, in_box, prompt_active, game_start
   );

   modport slave (
      input  pix_x, pix_y, pix_valid, frame_start, key_valid, game_over, letter_pix,
      output letter_x, letter_y, pix_data, pix_data_valid, in_box, prompt_active, game_start
   );
endinterface

// File: rtl/prompt_screen_ctrl.sv
// "PRESS ANY KEY" start-screen overlay: maps pixels into glyph space, blinks the
// prompt, waits for a key and hands over to the game with a one-cycle game_start.
`timescale 1ns/1ps
module prompt_screen_ctrl #(
   parameter int          TXT_X0       = 248,
   parameter int          TXT_Y0       = 232,
   parameter int          TXT_W        = 208,
   parameter int          TXT_H        = 16,
   parameter int          SCALE_SH     = 0,
   parameter int          ARM_FRAMES   = 60,
   parameter int          BLINK_FRAMES = 30,
   parameter int          ACK_FRAMES   = 20,
   parameter logic [15:0] FG_COLOR     = 16'hFFFF,
   parameter logic [15:0] BG_COLOR     = 16'h0000
) (
   input  logic                 vga_clk,
   input  logic                 sys_rst,
   prompt_screen_ctrl_if.slave  bus
);
   localparam int         FCNT_W = 8;
   localparam logic [9:0] X0     = 10'(TXT_X0);
   localparam logic [9:0] Y0     = 10'(TXT_Y0);
   localparam logic [9:0] BOX_W  = 10'(TXT_W << SCALE_SH);
   localparam logic [9:0] BOX_H  = 10'(TXT_H << SCALE_SH);

   typedef enum logic [1:0] {S_ARM, S_WAIT, S_ACK, S_RUN} state_t;

   state_t              state_q, state_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic                visible_q, visible_d;
   logic                gs_q, gs_d;

   logic [9:0]          dx, dy;
   logic                hit_d;
   logic [7:0]          lx_d, ly_d;
   logic [15:0]         pix_d;
   logic                hit_p1_q, vld_p1_q;
   logic [7:0]          lx_p1_q, ly_p1_q;
   logic                in_box_p2_q, vld_p2_q;
   logic [15:0]         pix_p2_q;

   // Stage 1: box hit test and glyph coordinates; wrap-around makes left/above misses
   always_comb begin
      dx    = bus.pix_x - X0;
      dy    = bus.pix_y - Y0;
      hit_d = bus.pix_valid && (dx < BOX_W) && (dy < BOX_H);
      lx_d  = hit_d ? 8'(dx >> SCALE_SH) : 8'd0;
      ly_d  = hit_d ? 8'(dy >> SCALE_SH) : 8'd0;
   end

   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         hit_p1_q <= 1'b0;
         vld_p1_q <= 1'b0;
         lx_p1_q  <= 8'd0;
         ly_p1_q  <= 8'd0;
      end else begin
         hit_p1_q <= hit_d;
         vld_p1_q <= bus.pix_valid;
         lx_p1_q  <= lx_d;
         ly_p1_q  <= ly_d;
      end
   end

   // Stage 2: colour the glyph bit returned by the bitmap for the stage-1 coordinates
   always_comb begin
      pix_d = (hit_p1_q && visible_q && bus.letter_pix) ? FG_COLOR : BG_COLOR;
   end

   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         in_box_p2_q <= 1'b0;
         vld_p2_q    <= 1'b0;
         pix_p2_q    <= 16'd0;
      end else begin
         in_box_p2_q <= hit_p1_q;
         vld_p2_q    <= vld_p1_q;
         pix_p2_q    <= pix_d;
      end
   end

   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= S_ARM;
         fcnt_q    <= '0;
         visible_q <= 1'b1;
         gs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         fcnt_q    <= fcnt_d;
         visible_q <= visible_d;
         gs_q      <= gs_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      fcnt_d    = fcnt_q;
      visible_d = visible_q;
      gs_d      = 1'b0;
      case (state_q)
         S_ARM: begin
            visible_d = 1'b1;
            if (bus.frame_start) begin
               if (fcnt_q == FCNT_W'(ARM_FRAMES - 1)) begin
                  state_d = S_WAIT;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d  = fcnt_q + 1'b1;
               end
            end
         end
         S_WAIT: begin
            // A key arriving with frame_start pre-empts the blink toggle
            if (bus.key_valid) begin
               state_d   = S_ACK;
               fcnt_d    = '0;
               visible_d = 1'b1;
            end else if (bus.frame_start) begin
               if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                  fcnt_d    = '0;
                  visible_d = ~visible_q;
               end else begin
                  fcnt_d    = fcnt_q + 1'b1;
               end
            end
         end
         S_ACK: begin
            visible_d = 1'b1;
            if (bus.frame_start) begin
               if (fcnt_q == FCNT_W'(ACK_FRAMES - 1)) begin
                  state_d   = S_RUN;
                  fcnt_d    = '0;
                  visible_d = 1'b0;
                  gs_d      = 1'b1;
               end else begin
                  fcnt_d    = fcnt_q + 1'b1;
               end
            end
         end
         default: begin
            visible_d = 1'b0;
            if (bus.game_over) begin
               state_d   = S_ARM;
               fcnt_d    = '0;
               visible_d = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      bus.prompt_active  = (state_q != S_RUN);
      bus.game_start     = gs_q;
      bus.letter_x       = lx_p1_q;
      bus.letter_y       = ly_p1_q;
      bus.in_box         = in_box_p2_q;
      bus.pix_data       = pix_p2_q;
      bus.pix_data_valid = vld_p2_q;
   end
endmodule
